// File: rtl/apb_ic_arbiter_qos_pkg.sv
// Shared definitions for the APB interconnect arbiters: mode encodings and
// an index-width helper used by the arbiter and the interconnect mux.
package apb_ic_arbiter_qos_pkg;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  // $clog2 with a floor of 1 so that single-entry fields stay legal
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_ic_arbiter_qos_if.sv
// Request/grant bundle between the cluster cores' APB master ports (master)
// and the master-side arbiter (slave).
interface apb_ic_arbiter_qos_if
  import apb_ic_arbiter_qos_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_W       = clog2_min1(NUM_MASTERS)
) ();

  logic [NUM_MASTERS-1:0] reqs;
  logic                   done;
  logic                   mode;
  logic [NUM_MASTERS-1:0] grants;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;

  modport master (
    output reqs, done, mode,
    input  grants, grant_idx, grant_valid
  );

  modport slave (
    input  reqs, done, mode,
    output grants, grant_idx, grant_valid
  );

endinterface

// File: rtl/apb_ic_rr_pick.sv
// Combinational pick: rotate requests to start at start_idx (or 0 in fixed
// mode), take the lowest set bit, then rotate the result back.
module apb_ic_rr_pick
  import apb_ic_arbiter_qos_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     reqs,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             mode,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Modulo-N add of two in-range indices; handles non-power-of-2 N
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(N)) s = s - (IDX_W+1)'(N);
    return s[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] pos;
  logic [N-1:0]     rot;
  logic             found;

  always_comb begin
    base  = (mode == ARB_MODE_FIXED) ? '0 : start_idx;
    rot   = '0;
    pos   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = reqs[wrap_add(base, IDX_W'(i))];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        pos   = IDX_W'(i);
        found = 1'b1;
      end
    end
    idx    = wrap_add(base, pos);
    onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    any    = |reqs;
  end

endmodule

// File: rtl/apb_ic_arbiter_qos.sv
// APB master arbiter: round-robin with per-owner transfer quota, or fixed
// priority, selected at run time. Grants are registered and always one-hot.
module apb_ic_arbiter_qos
  import apb_ic_arbiter_qos_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MAX_HOLD    = 2,
  parameter int unsigned IDX_W       = clog2_min1(NUM_MASTERS)
) (
  input  logic                clk,
  input  logic                reset,
  apb_ic_arbiter_qos_if.slave bus
);

  localparam int unsigned          HOLD_W    = clog2_min1(MAX_HOLD);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] grants_q, grants_d, pick_onehot;
  logic [IDX_W-1:0]       idx_q, idx_d, start_idx, pick_idx;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   pick_any, owner_req, rearb;

  // grants_q is one-hot, so this is reqs[owner]
  assign owner_req = |(grants_q & bus.reqs);
  assign rearb     = !owner_req
                  || (bus.done && (bus.mode == ARB_MODE_FIXED || hold_q == HOLD_LAST));
  assign start_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  apb_ic_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .reqs      (bus.reqs),
    .start_idx (start_idx),
    .mode      (bus.mode),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    grants_d = grants_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    if (rearb) begin
      // With no requester the grant parks on the current owner
      hold_d = '0;
      if (pick_any) begin
        grants_d = pick_onehot;
        idx_d    = pick_idx;
      end
    end else if (bus.done && hold_q != HOLD_LAST) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= NUM_MASTERS'(1);
      idx_q    <= '0;
      hold_q   <= '0;
    end else begin
      grants_q <= grants_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.grants      = grants_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = owner_req;

endmodule

// File: tb/tb_apb_ic_arbiter_qos.sv
// Bench for apb_ic_arbiter_qos: directed scenarios on a 4-master instance,
// then random traffic on 4- and 5-master instances against a reference model.
module tb_apb_ic_arbiter_qos;
  import apb_ic_arbiter_qos_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  apb_ic_arbiter_qos_if #(.NUM_MASTERS(4), .IDX_W(2)) b4 ();
  apb_ic_arbiter_qos_if #(.NUM_MASTERS(5), .IDX_W(3)) b5 ();

  apb_ic_arbiter_qos #(.NUM_MASTERS(4), .MAX_HOLD(2), .IDX_W(2)) dut4 (
    .clk (clk), .reset (reset), .bus (b4.slave)
  );
  apb_ic_arbiter_qos #(.NUM_MASTERS(5), .MAX_HOLD(3), .IDX_W(3)) dut5 (
    .clk (clk), .reset (reset), .bus (b5.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one clock of arbitration from the rule set
  function automatic void model_step(input int n, input int mh, input int unsigned rq,
                                     input bit dn, input bit md,
                                     inout int own, inout int hold);
    bit rearb;
    bit found;
    int c;
    rearb = (((rq >> own) & 1) == 0) || (dn && md) || (dn && !md && hold == mh - 1);
    if (rearb) begin
      hold = 0;
      if (rq != 0) begin
        found = 0;
        if (md) begin
          for (int k = 0; k < n; k++)
            if (!found && ((rq >> k) & 1) == 1) begin own = k; found = 1; end
        end else begin
          for (int k = 1; k <= n; k++) begin
            c = (own + k) % n;
            if (!found && ((rq >> c) & 1) == 1) begin own = c; found = 1; end
          end
        end
      end
    end else if (dn && hold < mh - 1) begin
      hold = hold + 1;
    end
  endfunction

  task automatic step4(input logic [3:0] r, input bit d, input bit m);
    b4.reqs = r; b4.done = d; b4.mode = m;
    @(posedge clk); #1;
    b4.done = 1'b0;
  endtask

  int unsigned r4, r5;
  bit d4, d5, m4, m5;
  int own4, h4, own5, h5;

  initial begin
    reset = 1'b1;
    b4.reqs = '0; b4.done = 1'b0; b4.mode = 1'b0;
    b5.reqs = '0; b5.done = 1'b0; b5.mode = 1'b0;
    #3;
    check_eq("rst_grants", b4.grants, 32'h1);
    check_eq("rst_idx",    b4.grant_idx, 32'h0);
    check_eq("rst_valid",  b4.grant_valid, 32'h0);
    check_eq("rst_grants5", b5.grants, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step4(4'b0000, 0, 0);
      check_eq("idle_grants", b4.grants, 32'h1);
    end

    // Round-robin quota
    step4(4'b0110, 0, 0);  check_eq("rr_first",  b4.grants, 32'h2);
    check_eq("rr_first_idx", b4.grant_idx, 32'h1);
    step4(4'b0110, 1, 0);  check_eq("rr_hold1",  b4.grants, 32'h2);
    step4(4'b0110, 1, 0);  check_eq("rr_quota",  b4.grants, 32'h4);
    step4(4'b0110, 1, 0);  check_eq("rr_hold2",  b4.grants, 32'h4);
    step4(4'b0110, 1, 0);  check_eq("rr_wrap",   b4.grants, 32'h2);

    // Owner drop
    step4(4'b0100, 0, 0);  check_eq("drop",      b4.grants, 32'h4);
    check_eq("drop_idx", b4.grant_idx, 32'h2);

    // Fixed priority without preemption, then done
    for (int i = 0; i < 5; i++) begin
      step4(4'b0111, 0, 1);
      check_eq("fix_nopre", b4.grants, 32'h4);
    end
    step4(4'b0111, 1, 1);  check_eq("fix_done",  b4.grants, 32'h1);

    // Park then new requester
    step4(4'b0100, 0, 1);  check_eq("to_owner2", b4.grants, 32'h4);
    step4(4'b0000, 0, 0);  check_eq("park",      b4.grants, 32'h4);
    check_eq("park_idx",   b4.grant_idx, 32'h2);
    check_eq("park_valid", b4.grant_valid, 32'h0);
    step4(4'b1000, 0, 0);  check_eq("unpark",    b4.grants, 32'h8);
    check_eq("unpark_valid", b4.grant_valid, 32'h1);

    // Async reset while owner 3 holds with hold_cnt=1
    step4(4'b1000, 1, 0);  check_eq("pre_rst",   b4.grants, 32'h8);
    #2 reset = 1'b1;
    #1;
    check_eq("async_grants", b4.grants, 32'h1);
    check_eq("async_idx",    b4.grant_idx, 32'h0);
    check_eq("async_valid",  b4.grant_valid, 32'h0);
    #1 reset = 1'b0;
    step4(4'b1000, 0, 0);  check_eq("post_rst",  b4.grants, 32'h8);
    step4(4'b1000, 1, 0);  check_eq("post_d1",   b4.grants, 32'h8);
    step4(4'b1000, 1, 0);  check_eq("post_d2",   b4.grants, 32'h8);
    check_eq("post_idx", b4.grant_idx, 32'h3);

    // Random traffic on both instances
    b4.reqs = '0; b4.done = 1'b0; b4.mode = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    own4 = 0; h4 = 0; own5 = 0; h5 = 0; m4 = 0; m5 = 0;
    repeat (1500) begin
      check_eq("rnd4_grants", b4.grants, 32'h1 << own4);
      check_eq("rnd4_idx",    b4.grant_idx, own4);
      check_eq("rnd5_grants", b5.grants, 32'h1 << own5);
      check_eq("rnd5_idx",    b5.grant_idx, own5);
      r4 = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) r4 = r4 | (32'h1 << own4);
      d4 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) m4 = ~m4;
      r5 = $urandom_range(0, 31);
      if ($urandom_range(0, 3) != 0) r5 = r5 | (32'h1 << own5);
      if ($urandom_range(0, 7) == 0) r5 = 0;
      d5 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) m5 = ~m5;
      b4.reqs = r4[3:0]; b4.done = d4; b4.mode = m4;
      b5.reqs = r5[4:0]; b5.done = d5; b5.mode = m5;
      #1;
      check_eq("rnd4_valid", b4.grant_valid, (r4 >> own4) & 1);
      check_eq("rnd5_valid", b5.grant_valid, (r5 >> own5) & 1);
      model_step(4, 2, r4, d4, m4, own4, h4);
      model_step(5, 3, r5, d5, m5, own5, h5);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_ic_arbiter_qos.md
Name: apb_ic_arbiter_qos

Overview:
Next-generation APB interconnect master arbiter, successor to apb_ic_arbiter_v2, with a parametrised master count. Selects between round-robin and fixed-priority modes at run time. Holds a grant across transfers up to a quota, then forces rotation to prevent starvation. Sits between the cluster cores' APB master ports and the shared APB interconnect mux, which uses grants and grant_idx to steer the bus.

Parameters:
NUM_MASTERS, 4, number of requesting masters; must be at least 2.
MAX_HOLD, 2, number of completed transfers an owner may hold while others wait (round-robin mode); must be at least 1.
IDX_W, $clog2(NUM_MASTERS), width of grant_idx.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
reqs  in  NUM_MASTERS  per-master request, held high for the whole transfer.
done  in  1  single-cycle pulse at transfer completion (PSEL&PENABLE&PREADY of the shared bus).
mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest).
grants  out  NUM_MASTERS  registered one-hot grant; never zero and never multi-hot.
grant_idx  out  IDX_W  binary index of the set bit in grants.
grant_valid  out  1  |(grants & reqs).

Behaviour:
- Reset: asynchronous, active-high. Immediately forces grants=...0001, grant_idx=0, hold_cnt=0. grant_valid follows reqs[0] combinationally. Reset is asserted mid-transfer with no other recovery; the transfer is abandoned.
- Owner: the master whose grants bit is set. All state updates happen on the rising clk edge. A new grant appears the cycle after the decision (1-cycle latency).
- Re-arbitration condition rearb, evaluated every cycle:
  - reqs[owner]==0, or
  - done && mode==1, or
  - done && mode==0 && hold_cnt==MAX_HOLD-1.
- Selection when rearb and reqs!=0:
  - mode 0: first requester searching owner+1, owner+2, … with wrap-around, owner itself last.
  - mode 1: lowest-index requester.
  - New owner takes grants; hold_cnt is cleared to 0 even if the owner is re-selected.
- rearb with reqs==0: park. grants unchanged, hold_cnt cleared, grant_valid=0.
- No rearb and done: hold_cnt += 1, saturating at MAX_HOLD-1.
- No rearb and no done: all state held.
- Simultaneous done and owner dropping reqs: counts as one rearb; the owner's bit is excluded from selection.
- Requests from non-owners never preempt mid-transfer. Preemption happens only at a done or when the owner drops its request.
- mode may change any cycle; it is sampled only at the rearb evaluation.
- MAX_HOLD=1: in mode 0, every done rotates when another master is requesting.
- grant_idx is registered alongside grants and always consistent with it.
- Widths:
  - hold_cnt width is max(1,$clog2(MAX_HOLD)).
  - IDX_W is floored at 1.
  - Index arithmetic wraps modulo NUM_MASTERS; non-power-of-2 counts must wrap correctly (e.g. 5 → index 4 wraps to 0).

Decomposition:
- Shared header apb_ic_defs.vh holds:
  - ARB_MODE_RR=1'b0 and ARB_MODE_FIXED=1'b1;
  - a clog2-with-floor-of-1 macro, shared with the interconnect mux.
- One combinational sub-module, apb_ic_rr_pick (params N; inputs reqs, start_idx, mode; outputs onehot, idx, any). It does the rotate, priority-encode and unrotate; it is reused by the slave-side arbiter.
- Top level holds the owner/hold_cnt registers and the rearb logic.

Test Plan:
1. Reset and idle: reset=1 with reqs=0000 → grants=0001, grant_idx=0, grant_valid=0. Release reset and keep reqs=0000 for 5 cycles → grants stays 0001.
2. Round-robin quota (NUM_MASTERS=4, MAX_HOLD=2, mode=0):
   - owner 0, reqs=0110 → grants=0010 one cycle later;
   - hold reqs and pulse done twice → grants=0100 the cycle after the 2nd done;
   - two further dones → grants=0010.
3. Owner drop: owner 1, reqs changes 0110→0100 with no done → grants=0100 next cycle, hold_cnt=0.
4. Fixed priority, mode=1:
   - owner 2, reqs=0111, no done for 5 cycles → grants stays 0100 (no preemption);
   - one done pulse → grants=0001 next cycle.
5. Park: owner 2, reqs→0000 → grants stays 0100, grant_idx=2, grant_valid=0. Then reqs=1000 → grants=1000 next cycle.
6. Async reset mid-hold: owner 3 with hold_cnt=1; assert reset between clock edges → grants=0001 before the next edge. After release with reqs=1000 → 1000 granted next cycle and holds for 2 dones.
